// File: rtl/vid_timing_meas_pkg.sv
// +----------------------------------------------------------------------+
// | vid_timing_meas_pkg : shared constants for the video timing monitor  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vid_timing_meas_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam int unsigned ERR_HTOTAL = 0;
  localparam int unsigned ERR_HACT   = 1;
  localparam int unsigned ERR_HPW    = 2;
  localparam int unsigned ERR_VTOTAL = 3;
  localparam int unsigned ERR_VACT   = 4;
  localparam int unsigned ERR_VPW    = 5;

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef struct packed {
    logic [11:0] htotal;
    logic [11:0] hact;
    logic [11:0] hpw;
  } line_meas_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 12'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vid_crc16_24.sv
// +----------------------------------------------------------------------+
// | vid_crc16_24 : CRC-16-CCITT next state for 24 data bits, MSB first   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vid_crc16_24
  import vid_timing_meas_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

`default_nettype wire

// File: rtl/vid_timing_meas.sv
// +----------------------------------------------------------------------+
// | vid_timing_meas : DE/Vsync/Hsync timing monitor with lock detection  |
// | Optional frame CRC when VID_MEAS_CRC_EN is defined.  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module vid_timing_meas
  import vid_timing_meas_pkg::*;
#(
  parameter logic [11:0] V_ACT       = 12'd2048,
  parameter logic [11:0] V_PW        = 12'd2,
  parameter logic [11:0] V_BP        = 12'd2,
  parameter logic [11:0] V_FP        = 12'd192,
  parameter logic [11:0] H_ACT       = 12'd2048,
  parameter logic [11:0] H_PW        = 12'd42,
  parameter logic [11:0] H_BP        = 12'd20,
  parameter logic [11:0] H_FP        = 12'd90,
  parameter logic [7:0]  RGB_PORT    = 8'd1,
  parameter logic [3:0]  LOCK_FRAMES = 4'd3
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      DE,
  input  logic                      Vsync,
  input  logic                      Hsync,
  input  logic [RGB_PORT*24-1:0]    data_rgb,
  output logic                      meas_valid,
  output logic [11:0]               meas_htotal,
  output logic [11:0]               meas_hact,
  output logic [11:0]               meas_hpw,
  output logic [11:0]               meas_vtotal,
  output logic [11:0]               meas_vact,
  output logic [11:0]               meas_vpw,
  output logic [5:0]                err,
  output logic                      nosync,
  output logic                      locked,
  output logic [15:0]               frame_crc
);

  localparam logic [11:0] HTOT = H_ACT + H_PW + H_BP + H_FP;
  localparam logic [11:0] VTOT = V_ACT + V_PW + V_BP + V_FP;

  logic        de_q, vs_q, hs_q;
  logic        de_rise, vs_rise, hs_rise;
  logic [1:0]  state;
  logic [11:0] h_cnt, hpw_cnt, hact_cnt;
  logic [11:0] line_htotal, line_hpw, line_hact;
  logic [11:0] v_cnt, vpw_cnt, vact_cnt;
  logic [3:0]  good_cnt, good_next;
  logic        meas_now;
  line_meas_t  cur_line;
  logic [5:0]  err_now;
  logic        unused_rgb;

  assign unused_rgb = ^data_rgb;

  assign de_rise = DE    & ~de_q;
  assign vs_rise = Vsync & ~vs_q;
  assign hs_rise = Hsync & ~hs_q;

  assign meas_now = en && (state == ST_MEAS) && vs_rise && !nosync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      de_q <= DE;
      vs_q <= Vsync;
      hs_q <= Hsync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= ST_SYNC;
        ST_SYNC: if (vs_rise) state <= ST_MEAS;
        ST_MEAS: if (nosync)  state <= ST_SYNC;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // hact tracks the last line that carried DE, so blanking lines at the
  // bottom of the frame do not hide the active width
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      h_cnt       <= '0;
      hpw_cnt     <= '0;
      hact_cnt    <= '0;
      line_htotal <= '0;
      line_hpw    <= '0;
      line_hact   <= '0;
    end else begin
      if (hs_rise) begin
        h_cnt       <= 12'd1;
        hpw_cnt     <= 12'd1;
        hact_cnt    <= {11'd0, DE};
        line_htotal <= h_cnt;
        line_hpw    <= hpw_cnt;
      end else begin
        h_cnt    <= sat_inc(h_cnt, 1'b1);
        hpw_cnt  <= sat_inc(hpw_cnt, Hsync);
        hact_cnt <= sat_inc(hact_cnt, DE);
      end
      if (vs_rise)
        line_hact <= '0;
      else if (hs_rise && (hact_cnt != '0))
        line_hact <= hact_cnt;
    end
  end

  // A coincident Hsync rise closes the old frame's last line but is the
  // first line of the new frame
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      v_cnt    <= '0;
      vpw_cnt  <= '0;
      vact_cnt <= '0;
    end else if (vs_rise) begin
      v_cnt    <= {11'd0, hs_rise};
      vpw_cnt  <= {11'd0, hs_rise};
      vact_cnt <= {11'd0, de_rise};
    end else begin
      v_cnt    <= sat_inc(v_cnt, hs_rise);
      vpw_cnt  <= sat_inc(vpw_cnt, hs_rise & Vsync);
      vact_cnt <= sat_inc(vact_cnt, de_rise);
    end
  end

  always_comb begin
    cur_line.htotal = hs_rise ? h_cnt : line_htotal;
    cur_line.hpw    = hs_rise ? hpw_cnt : line_hpw;
    cur_line.hact   = (hs_rise && (hact_cnt != '0)) ? hact_cnt : line_hact;
    err_now             = '0;
    err_now[ERR_HTOTAL] = (cur_line.htotal != HTOT);
    err_now[ERR_HACT]   = (cur_line.hact   != H_ACT);
    err_now[ERR_HPW]    = (cur_line.hpw    != H_PW);
    err_now[ERR_VTOTAL] = (v_cnt           != VTOT);
    err_now[ERR_VACT]   = (vact_cnt        != V_ACT);
    err_now[ERR_VPW]    = (vpw_cnt         != V_PW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_valid  <= 1'b0;
      meas_htotal <= '0;
      meas_hact   <= '0;
      meas_hpw    <= '0;
      meas_vtotal <= '0;
      meas_vact   <= '0;
      meas_vpw    <= '0;
      err         <= '0;
    end else begin
      meas_valid <= meas_now;
      if (meas_now) begin
        meas_htotal <= cur_line.htotal;
        meas_hact   <= cur_line.hact;
        meas_hpw    <= cur_line.hpw;
        meas_vtotal <= v_cnt;
        meas_vact   <= vact_cnt;
        meas_vpw    <= vpw_cnt;
        err         <= err_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      nosync <= 1'b0;
    else if (hs_rise)
      nosync <= 1'b0;
    else if (h_cnt == CNT_MAX)
      nosync <= 1'b1;
  end

  assign good_next = (good_cnt == LOCK_FRAMES) ? LOCK_FRAMES : good_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n || !en || nosync) begin
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (meas_now) begin
      if (err_now == '0) begin
        good_cnt <= good_next;
        locked   <= (good_next == LOCK_FRAMES);
      end else begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

`ifdef VID_MEAS_CRC_EN
  logic [15:0] crc_acc, crc_seed, crc_step;

  assign crc_seed = vs_rise ? CRC_INIT : crc_acc;

  vid_crc16_24 u_crc (
    .crc_in  (crc_seed),
    .data    (data_rgb[23:0]),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !en)
      crc_acc <= CRC_INIT;
    else if (DE)
      crc_acc <= crc_step;
    else if (vs_rise)
      crc_acc <= CRC_INIT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_crc <= '0;
    else if (meas_now)
      frame_crc <= crc_acc;
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

`default_nettype wire
